// File: rtl/regbus_master_pkg.sv
// Shared definitions for the register-bus master: command byte layout,
// response codes and FSM state encoding.
// Optional feature macro: REGBUS_WRITE_ACK_EN (adds the TX_ACK state).
package regbus_master_pkg;

    localparam int ADDR_W      = 5;
    localparam int DATA_W      = 16;
    localparam int CMD_WR_BIT  = 7;
    localparam int CMD_RSV_HI  = 6;
    localparam int CMD_RSV_LO  = 5;
    localparam int CMD_ADDR_HI = 4;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic [7:0] ACK = 8'hA5;
    localparam logic [7:0] NAK = 8'h5A;

    typedef enum logic [3:0] {
        ST_IDLE      = 4'd0,
        ST_GET_HI    = 4'd1,
        ST_GET_LO    = 4'd2,
        ST_WR_STB    = 4'd3,
        ST_RD_SETUP  = 4'd4,
        ST_RD_SAMPLE = 4'd5,
        ST_TX_HI     = 4'd6,
        ST_TX_LO     = 4'd7
`ifdef REGBUS_WRITE_ACK_EN
        ,
        ST_TX_ACK    = 4'd8
`endif
    } state_t;

endpackage

// File: rtl/regbus_master_if.sv
// Host link of the register-bus master: command byte stream in,
// response byte stream out, both valid/ready.
interface regbus_master_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        input  rx_data, rx_valid, tx_ready,
        output rx_ready, tx_data, tx_valid
    );

    modport slave (
        output rx_data, rx_valid, tx_ready,
        input  rx_ready, tx_data, tx_valid
    );

endinterface

// File: rtl/regbus_master_timeout.sv
// Inter-byte idle counter. Counts enabled cycles, clears on request and
// flags the cycle on which the LIMIT-th idle cycle completes.
module regbus_master_timeout #(
    parameter int unsigned LIMIT = 1000000
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CNT_W = $clog2(LIMIT + 1);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_r;

    // Idle-cycle counter: clear wins over count.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {CNT_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Terminal count only while counting, so an accepted byte masks it.
    assign tc = en && (cnt_r == TERM);

endmodule

// File: rtl/regbus_master.sv
// Register-bus master: parses host command bytes, runs one write or read
// cycle on the 16-bit tri-state register bus, streams read data back.
// Optional feature macro: REGBUS_WRITE_ACK_EN (ACK/NAK response bytes).
module regbus_master
    import regbus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1000000,
    parameter int          ERR_W          = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    regbus_master_if.master      host,
    output logic [ADDR_W-1:0]    bus_addr,
    output logic                 bus_write,
    inout  wire  [DATA_W-1:0]    bus_data,
    output logic                 busy,
    output logic [ERR_W-1:0]     err_count
);

    state_t             state_r, state_s;
    logic               rx_fire_s, tx_fire_s, in_get_s;
    logic               err_inc_s, tmo_clr_s, tmo_en_s, tmo_tc_s;
    logic               rx_ready_s, tx_valid_s;
    logic               rx_ready_r, tx_valid_r, bus_write_r, busy_r;
    logic [7:0]         tx_data_r;
    logic [ADDR_W-1:0]  bus_addr_r;
    logic [DATA_W-1:0]  data_q_r;
    logic [ERR_W-1:0]   err_r;

    assign rx_fire_s = host.rx_valid && rx_ready_r;
    assign tx_fire_s = tx_valid_r && host.tx_ready;
    assign in_get_s  = (state_r == ST_GET_HI) || (state_r == ST_GET_LO);
    assign tmo_en_s  = in_get_s && !rx_fire_s;
    assign tmo_clr_s = !in_get_s || rx_fire_s;

    regbus_master_timeout #(.LIMIT(TIMEOUT_CYCLES)) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (tmo_clr_s),
        .en    (tmo_en_s),
        .tc    (tmo_tc_s)
    );

    // Next-state decode plus the Moore output values of the next state.
    always_comb begin
        state_s   = state_r;
        err_inc_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rx_fire_s) begin
                    if (host.rx_data[CMD_RSV_HI:CMD_RSV_LO] != 2'b00) begin
                        err_inc_s = 1'b1;
`ifdef REGBUS_WRITE_ACK_EN
                        state_s   = ST_TX_ACK;
`else
                        state_s   = ST_IDLE;
`endif
                    end else if (host.rx_data[CMD_WR_BIT] == CMD_WRITE) begin
                        state_s = ST_GET_HI;
                    end else begin
                        state_s = ST_RD_SETUP;
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_GET_HI: begin
                if (rx_fire_s) begin
                    state_s = ST_GET_LO;
                end else if (tmo_tc_s) begin
                    state_s   = ST_IDLE;
                    err_inc_s = 1'b1;
                end else begin
                    state_s = ST_GET_HI;
                end
            end
            ST_GET_LO: begin
                if (rx_fire_s) begin
                    state_s = ST_WR_STB;
                end else if (tmo_tc_s) begin
                    state_s   = ST_IDLE;
                    err_inc_s = 1'b1;
                end else begin
                    state_s = ST_GET_LO;
                end
            end
`ifdef REGBUS_WRITE_ACK_EN
            ST_WR_STB:    state_s = ST_TX_ACK;
            ST_TX_ACK:    state_s = tx_fire_s ? ST_IDLE : ST_TX_ACK;
`else
            ST_WR_STB:    state_s = ST_IDLE;
`endif
            ST_RD_SETUP:  state_s = ST_RD_SAMPLE;
            ST_RD_SAMPLE: state_s = ST_TX_HI;
            ST_TX_HI:     state_s = tx_fire_s ? ST_TX_LO : ST_TX_HI;
            ST_TX_LO:     state_s = tx_fire_s ? ST_IDLE : ST_TX_LO;
            default:      state_s = ST_IDLE;
        endcase

        rx_ready_s = (state_s == ST_IDLE) || (state_s == ST_GET_HI) ||
                     (state_s == ST_GET_LO);
`ifdef REGBUS_WRITE_ACK_EN
        tx_valid_s = (state_s == ST_TX_HI) || (state_s == ST_TX_LO) ||
                     (state_s == ST_TX_ACK);
`else
        tx_valid_s = (state_s == ST_TX_HI) || (state_s == ST_TX_LO);
`endif
    end

    // State and registered control outputs, all derived from the next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            rx_ready_r  <= 1'b0;
            tx_valid_r  <= 1'b0;
            bus_write_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            rx_ready_r  <= rx_ready_s;
            tx_valid_r  <= tx_valid_s;
            bus_write_r <= (state_s == ST_WR_STB);
            busy_r      <= (state_s != ST_IDLE);
        end
    end

    // Address, data holding register, response byte and error counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_addr_r <= {ADDR_W{1'b0}};
            data_q_r   <= {DATA_W{1'b0}};
            tx_data_r  <= 8'h00;
            err_r      <= {ERR_W{1'b0}};
        end else begin
            if (state_r == ST_IDLE && rx_fire_s &&
                host.rx_data[CMD_RSV_HI:CMD_RSV_LO] == 2'b00) begin
                bus_addr_r <= host.rx_data[CMD_ADDR_HI:0];
            end else begin
                bus_addr_r <= bus_addr_r;
            end

            if (state_r == ST_GET_HI && rx_fire_s) begin
                data_q_r[15:8] <= host.rx_data;
            end else if (state_r == ST_GET_LO && rx_fire_s) begin
                data_q_r[7:0] <= host.rx_data;
            end else if (state_r == ST_RD_SAMPLE) begin
                data_q_r <= bus_data;
            end else begin
                data_q_r <= data_q_r;
            end

            if (state_r == ST_RD_SAMPLE) begin
                tx_data_r <= bus_data[15:8];
            end else if (state_r == ST_TX_HI && tx_fire_s) begin
                tx_data_r <= data_q_r[7:0];
`ifdef REGBUS_WRITE_ACK_EN
            end else if (state_r == ST_WR_STB) begin
                tx_data_r <= ACK;
            end else if (state_s == ST_TX_ACK && state_r == ST_IDLE) begin
                tx_data_r <= NAK;
`endif
            end else begin
                tx_data_r <= tx_data_r;
            end

            if (err_inc_s && (err_r != {ERR_W{1'b1}})) begin
                err_r <= err_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
                err_r <= err_r;
            end
        end
    end

    // The write-strobe flop doubles as the bus output enable.
    assign bus_data      = bus_write_r ? data_q_r : 16'hzzzz;
    assign bus_addr      = bus_addr_r;
    assign bus_write     = bus_write_r;
    assign busy          = busy_r;
    assign err_count     = err_r;
    assign host.rx_ready = rx_ready_r;
    assign host.tx_valid = tx_valid_r;
    assign host.tx_data  = tx_data_r;

endmodule

// File: tb/tb_regbus_master.sv
// Bench for regbus_master paired with a register-file responder model.
module tb_regbus_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  bus_addr;
    logic        bus_write;
    wire  [15:0] bus_data;
    logic        busy;
    logic [1:0]  err_count;

    regbus_master_if h();

    regbus_master #(.TIMEOUT_CYCLES(16), .ERR_W(2)) dut (
        .clk       (clk),
        .reset     (reset),
        .host      (h),
        .bus_addr  (bus_addr),
        .bus_write (bus_write),
        .bus_data  (bus_data),
        .busy      (busy),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    // Register file responder: drives reads, captures writes on negedge.
    logic [15:0] rf [32] = '{default: 16'h0000};
    int          strobe_n = 0;
    assign bus_data = bus_write ? 16'hzzzz : rf[bus_addr];
    always @(negedge clk) begin
        if (bus_write) begin
            rf[bus_addr] <= bus_data;
            strobe_n     <= strobe_n + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input bit keep);
        int n = 0;
        h.rx_data  = b;
        h.rx_valid = 1'b1;
        while (!h.rx_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("rx_accept", {31'd0, h.rx_ready}, 32'd1);
        @(negedge clk);
        if (!keep) h.rx_valid = 1'b0;
    endtask

    task automatic recv_byte(input string nm, input logic [7:0] exp);
        int n = 0;
        h.tx_ready = 1'b1;
        while (!h.tx_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!h.tx_valid) check({nm, "_valid"}, {31'd0, h.tx_valid}, 32'd1);
        else             check(nm, {24'd0, h.tx_data}, {24'd0, exp});
        @(negedge clk);
        h.tx_ready = 1'b0;
    endtask

    // Full write command; checks the single strobe cycle that follows.
    task automatic do_write(input logic [7:0] cmd, input logic [15:0] d, input bit keep);
        int s0;
        send_byte(cmd, 1'b1);
        send_byte(d[15:8], 1'b1);
        s0 = strobe_n;
        send_byte(d[7:0], keep);
        check("wr_strobe", {31'd0, bus_write}, 32'd1);
        check("wr_addr", {27'd0, bus_addr}, {27'd0, cmd[4:0]});
        check("wr_data", {16'd0, bus_data}, {16'd0, d});
        check("wr_rx_ready_low", {31'd0, h.rx_ready}, 32'd0);
        @(negedge clk);
        check("wr_one_cycle", {31'd0, bus_write}, 32'd0);
        check("wr_strobe_count", strobe_n - s0, 32'd1);
`ifdef REGBUS_WRITE_ACK_EN
        recv_byte("wr_ack", 8'hA5);
`else
        check("wr_back_in_idle", {31'd0, h.rx_ready}, 32'd1);
`endif
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    typedef struct {
        logic [7:0]  wcmd;
        logic [15:0] wdata;
        logic [7:0]  rcmd;
        logic [7:0]  exp_hi;
        logic [7:0]  exp_lo;
    } vec_t;
    vec_t vecs[5];

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, cnt;
        logic [3:0] k;
        logic [15:0] d;
        vecs[0] = '{8'h83, 16'hBEEF, 8'h03, 8'hBE, 8'hEF};
        vecs[1] = '{8'h9F, 16'h1234, 8'h1F, 8'h12, 8'h34};
        vecs[2] = '{8'h90, 16'hFFFF, 8'h10, 8'hFF, 8'hFF};
        vecs[3] = '{8'h80, 16'h0001, 8'h00, 8'h00, 8'h01};
        vecs[4] = '{8'h8A, 16'h8000, 8'h0A, 8'h80, 8'h00};

        reset = 1'b1;
        h.rx_data = 8'h00; h.rx_valid = 1'b0; h.tx_ready = 1'b0;
        @(negedge clk);
        check("rst_rx_ready", {31'd0, h.rx_ready}, 32'd0);
        check("rst_tx_valid", {31'd0, h.tx_valid}, 32'd0);
        check("rst_bus_write", {31'd0, bus_write}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_bus_addr", {27'd0, bus_addr}, 32'd0);
        check("rst_tx_data", {24'd0, h.tx_data}, 32'd0);
        check("rst_err", {30'd0, err_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("idle_rx_ready", {31'd0, h.rx_ready}, 32'd1);

        // Table: write, then read back with latency check.
        for (int i = 0; i < 5; i++) begin
            do_write(vecs[i].wcmd, vecs[i].wdata, 1'b0);
            send_byte(vecs[i].rcmd, 1'b0);
            check("rd_busy", {31'd0, busy}, 32'd1);
            check("rd_lat0", {31'd0, h.tx_valid}, 32'd0);
            @(negedge clk);
            check("rd_lat1", {31'd0, h.tx_valid}, 32'd0);
            @(negedge clk);
            check("rd_lat2", {31'd0, h.tx_valid}, 32'd1);
            recv_byte("rd_hi", vecs[i].exp_hi);
            recv_byte("rd_lo", vecs[i].exp_lo);
            check("rd_done_idle", {31'd0, busy}, 32'd0);
        end

        // Read with host stalled for 20 cycles.
        send_byte(8'h07, 1'b0);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            check("stall_valid", {31'd0, h.tx_valid}, 32'd1);
            check("stall_data", {24'd0, h.tx_data}, 32'd0);
            check("stall_rx_ready", {31'd0, h.rx_ready}, 32'd0);
            @(negedge clk);
        end
        recv_byte("stall_hi", 8'h00);
        recv_byte("stall_lo", 8'h00);

        // Reserved bits set: rejected without bus activity.
        do_reset();
        s0 = strobe_n;
        send_byte(8'hC1, 1'b0);
        check("rsv_err", {30'd0, err_count}, 32'd1);
`ifdef REGBUS_WRITE_ACK_EN
        recv_byte("rsv_nak", 8'h5A);
`else
        cnt = 0;
        for (int i = 0; i < 4; i++) begin
            if (h.tx_valid || busy) cnt++;
            @(negedge clk);
        end
        check("rsv_silent", cnt, 32'd0);
`endif
        check("rsv_no_strobe", strobe_n - s0, 32'd0);
        send_byte(8'h03, 1'b0);
        recv_byte("rsv_next_hi", 8'hBE);
        recv_byte("rsv_next_lo", 8'hEF);

        // Inter-byte timeout after 16 idle cycles.
        do_reset();
        s0 = strobe_n;
        send_byte(8'h82, 1'b0);
        send_byte(8'h12, 1'b0);
        for (int i = 1; i < 16; i++) begin
            @(negedge clk);
            check("tmo_waiting", {31'd0, busy}, 32'd1);
        end
        @(negedge clk);
        check("tmo_abort", {31'd0, busy}, 32'd0);
        check("tmo_err", {30'd0, err_count}, 32'd1);
        check("tmo_no_strobe", strobe_n - s0, 32'd0);
        check("tmo_reg_kept", {16'd0, rf[2]}, 32'd0);
        do_write(8'h82, 16'h1234, 1'b0);
        check("tmo_retry", {16'd0, rf[2]}, 32'h1234);
        // Byte arriving on the limit cycle wins.
        send_byte(8'h82, 1'b0);
        repeat (15) @(negedge clk);
        check("tmo_edge_busy", {31'd0, busy}, 32'd1);
        do_write_tail: begin
            send_byte(8'h56, 1'b0);
            send_byte(8'h78, 1'b0);
            check("tmo_edge_strobe", {31'd0, bus_write}, 32'd1);
            @(negedge clk);
`ifdef REGBUS_WRITE_ACK_EN
            recv_byte("tmo_edge_ack", 8'hA5);
`endif
        end
        check("tmo_edge_reg", {16'd0, rf[2]}, 32'h5678);
        check("tmo_edge_err", {30'd0, err_count}, 32'd1);

        // Reset in GET_LO.
        send_byte(8'hA0, 1'b0);
`ifdef REGBUS_WRITE_ACK_EN
        recv_byte("pre_rst_nak", 8'h5A);
`endif
        check("pre_rst_err", {30'd0, err_count}, 32'd2);
        s0 = strobe_n;
        send_byte(8'h85, 1'b0);
        send_byte(8'hAA, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_getlo_rx_ready", {31'd0, h.rx_ready}, 32'd0);
        check("rst_getlo_busy", {31'd0, busy}, 32'd0);
        check("rst_getlo_addr", {27'd0, bus_addr}, 32'd0);
        check("rst_getlo_err", {30'd0, err_count}, 32'd0);
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check("rst_getlo_no_write", strobe_n - s0, 32'd0);
        check("rst_getlo_reg", {16'd0, rf[5]}, 32'd0);

        // Reset in TX_HI.
        send_byte(8'h03, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rst_txhi_pre", {31'd0, h.tx_valid}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        check("rst_txhi_valid", {31'd0, h.tx_valid}, 32'd0);
        check("rst_txhi_data", {24'd0, h.tx_data}, 32'd0);
        reset = 1'b0;
        h.tx_ready = 1'b1;
        cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (h.tx_valid) cnt++;
        end
        h.tx_ready = 1'b0;
        check("rst_txhi_no_tx", cnt, 32'd0);

        // Back-to-back writes 0x00..0x0F with rx_valid held high, read back.
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            do_write({3'b100, 1'b0, k}, {k, 4'hA, ~k, 4'h5}, 1'b1);
        end
        h.rx_valid = 1'b0;
        for (int i = 0; i < 16; i++) begin
            k = 4'(i);
            d = {k, 4'hA, ~k, 4'h5};
            send_byte({3'b000, 1'b0, k}, 1'b0);
            recv_byte("b2b_hi", d[15:8]);
            recv_byte("b2b_lo", d[7:0]);
        end

        // Error counter saturates at 3 with a 2-bit counter.
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            send_byte(8'hA0, 1'b0);
`ifdef REGBUS_WRITE_ACK_EN
            recv_byte("sat_nak", 8'h5A);
`endif
            check("err_sat", {30'd0, err_count}, (i > 3) ? 32'd3 : 32'(i));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
